// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer push port, FIFO status and transmitter send/ready handshake.
// master = producer/transmitter side, slave = the FIFO block.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_overflow;
  logic              tx_ready;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              tx_send;
  logic [DATA_W-1:0] tx_data;
  logic              busy;

  modport master (
    output wr_en, wr_data, clr_overflow, tx_ready,
    input  full, empty, level, overflow, tx_send, tx_data, busy
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_ready,
    output full, empty, level, overflow, tx_send, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO launching bytes into a UART transmitter; UART_TX_FIFO_STATS_EN adds drop/sent counters.
// Latency: a push into an empty FIFO launches one cycle after it lands; tx_send is a one-cycle pulse.
// Backpressure: launches wait for tx_ready; pushes into a full FIFO (with no launch) are dropped and set overflow.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
`ifdef UART_TX_FIFO_STATS_EN
  ,output logic [7:0]   drop_count
  ,output logic [15:0]  sent_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACK, DRAIN} state_t;

  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_q, level_nxt;
  logic              full_q, empty_q, overflow_q, tx_send_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              pop, push, drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_q && bus.tx_ready) begin
          pop       = 1'b1;
          state_nxt = ACK;
        end
      end
      // Ready falling is the transmitter's acknowledgement that it took the byte.
      ACK:     if (!bus.tx_ready) state_nxt = DRAIN;
      DRAIN:   if (bus.tx_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A launch in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push = bus.wr_en && (!full_q || pop);
  assign drop = bus.wr_en && full_q && !pop;

  always_comb begin
    level_nxt = level_q;
    if (push && !pop)      level_nxt = level_q + LVL_ONE;
    else if (pop && !push) level_nxt = level_q - LVL_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        tx_data_q <= mem[rd_ptr];
      end
      tx_send_q <= pop;
      level_q   <= level_nxt;
      full_q    <= (level_nxt == LVL_FULL);
      empty_q   <= (level_nxt == '0);
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.clr_overflow) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state != IDLE) || !empty_q;

`ifdef UART_TX_FIFO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      sent_count <= '0;
    end else begin
      // A drop coinciding with the clear is still counted, matching overflow.
      if (bus.clr_overflow)               drop_count <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (pop) sent_count <= sent_count + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo with a queue-based FIFO model and a
// behavioural transmitter that drops ready one cycle after seeing tx_send.
module tb_uart_tx_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  uart_tx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef UART_TX_FIFO_STATS_EN
  logic [7:0]  drop_count;
  logic [15:0] sent_count;
`endif

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef UART_TX_FIFO_STATS_EN
    ,.drop_count (drop_count)
    ,.sent_count (sent_count)
`endif
  );

  initial forever #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: manual ready, or automatic ready that falls after send and returns later.
  logic tx_auto     = 1'b0;
  logic man_ready   = 1'b1;
  logic model_ready = 1'b1;
  int   hold_min    = 1;
  int   hold_max    = 6;
  assign bus.tx_ready = tx_auto ? model_ready : man_ready;

  initial begin
    int  hold;
    bit  saw_send;
    hold = 0;
    saw_send = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_auto) begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) model_ready = 1'b1;
        end else if (saw_send) begin
          model_ready = 1'b0;
          hold = $urandom_range(hold_max, hold_min);
        end
        saw_send = bus.tx_send;
      end else begin
        saw_send = 0;
        hold = 0;
        model_ready = 1'b1;
      end
    end
  end

  // Launch recorder: data in order, plus whether each launch respected the ready-return gap.
  logic [DATA_W-1:0] got_q[$];
  bit                gap_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit have_prev = 0, rose = 0, prev_ready = 0;
  int rise_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (bus.tx_ready === 1'b1 && !prev_ready) begin
      rise_cyc = cyc;
      rose = 1;
    end
    prev_ready = (bus.tx_ready === 1'b1);
    if (bus.tx_send === 1'b1) begin
      got_q.push_back(bus.tx_data);
      gap_q.push_back(!have_prev || (rose && (cyc - rise_cyc >= 2)));
      have_prev = 1;
      rose = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    got_q.delete();
    gap_q.delete();
    exp_q.delete();
    have_prev = 0;
    rose = 0;
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge that sampled them.
  task automatic step(input bit we, input logic [DATA_W-1:0] d, input bit clr);
    bus.wr_en = we;
    bus.wr_data = d;
    bus.clr_overflow = clr;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(bus.empty && !bus.busy && bus.tx_ready === 1'b1) && n < budget) begin
      step(0, '0, 0);
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_drain_timeout: level=%0d busy=%0b after %0d cycles, expected idle", tag, bus.level, bus.busy, n);
    end
  endtask

  task automatic compare_launches(input string tag);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d launches expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s_data[%0d]: got %02h expected %02h", tag, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    tx_auto = 0; man_ready = 1;
    bus.wr_en = 0; bus.wr_data = '0; bus.clr_overflow = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(0, '0, 0);
    checks++; if (bus.level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    checks++; if (bus.tx_send !== 1'b0) begin fails++; $display("FAIL reset_tx_send: got %b expected 0", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h expected 00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single();
    clear_model();
    tx_auto = 1;
    step(1, 8'h55, 0);
    checks++; if (bus.tx_send !== 1'b0 || bus.level !== 5'd1 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL single_landed: send=%b level=%0d busy=%b expected 0/1/1", bus.tx_send, bus.level, bus.busy); end
    step(0, '0, 0);
    checks++; if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'h55) begin
      fails++; $display("FAIL single_launch: send=%b data=%02h expected 1/55", bus.tx_send, bus.tx_data); end
    checks++; if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      fails++; $display("FAIL single_empty: empty=%b level=%0d expected 1/0", bus.empty, bus.level); end
    step(0, '0, 0);
    checks++; if (bus.tx_send !== 1'b0 || bus.tx_data !== 8'h55) begin
      fails++; $display("FAIL single_pulse: send=%b data=%02h expected 0/55", bus.tx_send, bus.tx_data); end
    wait_idle(100, "single");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 5; r++) begin
      int n;
      clear_model();
      n = (r == 0) ? 5 : $urandom_range(12, 3);
      for (int i = 0; i < n; i++) begin
        logic [DATA_W-1:0] d;
        d = (r == 0) ? 8'(i + 1) : 8'($urandom);
        exp_q.push_back(d);
        step(1, d, 0);
        if (r != 0 && $urandom_range(3, 0) == 0) step(0, '0, 0);
      end
      wait_idle((r == 0) ? 100 : 300, "burst");
      compare_launches("burst");
      for (int i = 0; i < gap_q.size(); i++) begin
        checks++;
        if (gap_q[i] !== 1'b1) begin
          fails++; $display("FAIL burst_gap[%0d]: launch gap ok=%b expected 1", i, gap_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    clear_model();
    man_ready = 0;
    tx_auto = 0;
    step(0, '0, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [DATA_W-1:0] d;
      int lvl;
      d = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(d);
      step(1, d, 0);
      lvl = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      checks++; if (bus.level !== 5'(lvl)) begin
        fails++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, bus.level, lvl); end
      checks++; if (bus.overflow !== (i == DEPTH)) begin
        fails++; $display("FAIL fill_overflow[%0d]: got %b expected %b", i, bus.overflow, (i == DEPTH)); end
      checks++; if (bus.full !== (i + 1 >= DEPTH)) begin
        fails++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (i + 1 >= DEPTH)); end
    end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (drop_count !== 8'd1) begin fails++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
`endif
    checks++; if (got_q.size() !== 0) begin fails++; $display("FAIL fill_no_launch: got %0d launches expected 0", got_q.size()); end
  endtask

  task automatic test_clr_overflow();
    step(1, 8'($urandom), 1);
    checks++; if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin
      fails++; $display("FAIL clr_vs_drop: overflow=%b level=%0d expected 1/16", bus.overflow, bus.level); end
    step(0, '0, 1);
    checks++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL clr_alone: got %b expected 0", bus.overflow); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL drop_count_clr: got %0d expected 0", drop_count); end
`endif
  endtask

  task automatic test_push_on_launch();
    logic [DATA_W-1:0] d;
    d = 8'($urandom);
    man_ready = 1;
    step(1, d, 0);
    exp_q.push_back(d);
    checks++; if (bus.tx_send !== 1'b1 || bus.tx_data !== exp_q[0]) begin
      fails++; $display("FAIL full_launch: send=%b data=%02h expected 1/%02h", bus.tx_send, bus.tx_data, exp_q[0]); end
    checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL full_push: level=%0d full=%b overflow=%b expected 16/1/0", bus.level, bus.full, bus.overflow); end
    step(0, '0, 0);
    man_ready = 0;
    step(0, '0, 0);
    step(0, '0, 0);
    tx_auto = 1;
    wait_idle(800, "full");
    compare_launches("full");
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    clear_model();
    hold_min = 15; hold_max = 20;
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0);
    checks++; if (bus.level !== 5'd3 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL pre_reset: level=%0d busy=%b expected 3/1", bus.level, bus.busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.tx_send !== 1'b0 || bus.level !== 5'd0 || bus.empty !== 1'b1) begin
      fails++; $display("FAIL mid_reset: send=%b level=%0d empty=%b expected 0/0/1", bus.tx_send, bus.level, bus.empty); end
    tx_auto = 0;
    man_ready = 1;
    hold_min = 1; hold_max = 6;
    @(posedge clk); #1 reset = 1'b0;
    step(0, '0, 0);
    clear_model();
    tx_auto = 1;
    d = 8'($urandom);
    exp_q.push_back(d);
    step(1, d, 0);
    step(0, '0, 0);
    checks++; if (bus.tx_send !== 1'b1 || bus.tx_data !== d) begin
      fails++; $display("FAIL post_reset_launch: send=%b data=%02h expected 1/%02h", bus.tx_send, bus.tx_data, d); end
    wait_idle(100, "post_reset");
    compare_launches("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_clr_overflow();
    test_push_on_launch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
